// File: rtl/chord_pkg.sv
// rtl/chord_pkg.sv - shared CHORD widths, constants and result record
// Purpose: fixed-point widths matching the pipeline, PI in Q7.8, flip flag
//          bit positions and the corrected-result record.
// Ports:   none (package).
package chord_pkg;

  localparam int CHORD_WIDTH     = 16;
  localparam int CHORD_INT_BITS  = 7;
  localparam int CHORD_FRAC_BITS = 8;

  localparam logic [CHORD_WIDTH-1:0] PI_Q8 = 16'h0324;

  localparam int FLIP_NEG_X = 0;
  localparam int FLIP_NEG_Y = 1;

  typedef struct packed {
    logic [CHORD_WIDTH-1:0] degree;
    logic [CHORD_WIDTH-1:0] x;
    logic [CHORD_WIDTH-1:0] y;
    logic                   arctan;
  } chord_result_t;

endpackage

// File: rtl/chord_result_fifo.sv
// rtl/chord_result_fifo.sv - first-word-fall-through result FIFO
// Purpose: DEPTH-entry FIFO with wrap-bit pointers; the head is presented
//          combinationally and reads as zero while empty.
// Ports:   clk, reset (async, active-high); wr_en/wr_data push side;
//          rd_en pop side; rd_data head; empty; count occupancy;
//          drop pulses when a push is refused because the FIFO is full.
module chord_result_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 49
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              full;
  logic              do_rd;
  logic              do_wr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // A pop on the same edge frees the slot the push lands in, so a push while
  // full is only refused when nothing is leaving.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign drop  = wr_en && full && !do_rd;

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/chord_result_unfold.sv
// rtl/chord_result_unfold.sv - quadrant unfold, result FIFO and issue credit
// Purpose: undoes the CORDIC quadrant fold recorded in the flip flags,
//          buffers corrected results and returns issue credit to the front end.
//          Build option CHORD_RESULT_SAT_EN: saturate out-of-range results
//          instead of two's-complement wrap.
// Ports:   clk, reset (async, active-high); issue from the front end;
//          valid_in/degree_in/x_in/y_in/flip_in/arctan_en_in from the pipeline;
//          res_valid/res_ready handshake with res_degree/res_x/res_y/res_arctan;
//          credit_ok to the front end; overflow_err sticky drop flag.
module chord_result_unfold
  import chord_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int FLIP_FLAG_WIDTH = 2,
  parameter int DEPTH           = 8,
  parameter int MAX_INFLIGHT    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue,
  input  logic                       valid_in,
  input  logic [WIDTH-1:0]           degree_in,
  input  logic [WIDTH-1:0]           x_in,
  input  logic [WIDTH-1:0]           y_in,
  input  logic [FLIP_FLAG_WIDTH-1:0] flip_in,
  input  logic                       arctan_en_in,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH-1:0]           res_degree,
  output logic [WIDTH-1:0]           res_x,
  output logic [WIDTH-1:0]           res_y,
  output logic                       res_arctan,
  output logic                       credit_ok,
  output logic                       overflow_err
);

  localparam int XW = WIDTH + 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int DW = 3 * WIDTH + 1;

  localparam logic [IW-1:0] INFLIGHT_MAX = IW'(MAX_INFLIGHT);

  // Bring a WIDTH+1 intermediate back to WIDTH.
  function automatic logic [WIDTH-1:0] fit(input logic [XW-1:0] v);
`ifdef CHORD_RESULT_SAT_EN
    if (v[XW-1] != v[XW-2])
      fit = v[XW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      fit = v[WIDTH-1:0];
`else
    fit = v[WIDTH-1:0];
`endif
  endfunction

  logic [XW-1:0] deg_x, x_x, y_x, pi_x;
  logic [XW-1:0] deg_c, x_c, y_c;

  assign deg_x = {degree_in[WIDTH-1], degree_in};
  assign x_x   = {x_in[WIDTH-1], x_in};
  assign y_x   = {y_in[WIDTH-1], y_in};
  assign pi_x  = XW'(PI_Q8);

  always_comb begin
    deg_c = deg_x;
    x_c   = x_x;
    y_c   = y_x;
    if (arctan_en_in) begin
      case ({flip_in[FLIP_NEG_Y], flip_in[FLIP_NEG_X]})
        2'b01:   deg_c = pi_x - deg_x;
        2'b10:   deg_c = -deg_x;
        2'b11:   deg_c = deg_x - pi_x;
        default: deg_c = deg_x;
      endcase
    end else begin
      if (flip_in[FLIP_NEG_X]) x_c = -x_x;
      if (flip_in[FLIP_NEG_Y]) y_c = -y_x;
    end
  end

  logic          s1_valid;
  logic [DW-1:0] s1_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= valid_in;
      s1_data  <= {fit(deg_c), fit(x_c), fit(y_c), arctan_en_in};
    end
  end

  logic          fifo_empty;
  logic [PW-1:0] occupancy;
  logic          fifo_drop;
  logic [DW-1:0] head;

  chord_result_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (s1_valid),
    .wr_data (s1_data),
    .rd_en   (res_valid && res_ready),
    .rd_data (head),
    .empty   (fifo_empty),
    .count   (occupancy),
    .drop    (fifo_drop)
  );

  assign res_valid = !fifo_empty;
  assign {res_degree, res_x, res_y, res_arctan} = head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          overflow_err <= 1'b0;
    else if (fifo_drop) overflow_err <= 1'b1;
  end

  // Results still inside the pipeline; clamps at both ends so a return that
  // arrives after a reset cannot wrap the count.
  logic [IW-1:0] inflight;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else if (issue && !valid_in) begin
      if (inflight != INFLIGHT_MAX) inflight <= inflight + 1'b1;
    end else if (valid_in && !issue) begin
      if (inflight != '0) inflight <= inflight - 1'b1;
    end
  end

  // Every slot already promised: queued, in the correction stage, or in flight.
  assign credit_ok = (32'(occupancy) + 32'(s1_valid) + 32'(inflight)) < 32'(DEPTH);

endmodule
